// File: rtl/fifo_flex_if.sv
// Valid/ready stream bundle for fifo_flex: write side (din/input_*) and read side (qout/output_*).
// master is the environment that feeds and drains the FIFO; slave is the FIFO itself.
interface fifo_flex_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             input_valid;
  logic             input_ready;
  logic [WIDTH-1:0] qout;
  logic             output_valid;
  logic             output_ready;

  modport master (
    output din,
    output input_valid,
    output output_ready,
    input  input_ready,
    input  qout,
    input  output_valid
  );

  modport slave (
    input  din,
    input  input_valid,
    input  output_ready,
    output input_ready,
    output qout,
    output output_valid
  );
endinterface

// File: rtl/fifo_flex.sv
// Single-clock first-word-fall-through FIFO on a flop array, with fill level,
// programmable almost-full/almost-empty flags, synchronous flush and a high-watermark register.
module fifo_flex #(
  parameter int WIDTH                  = 8,
  parameter int LOG2_OF_DEPTH          = 4,
  parameter int ALMOST_FULL_THRESHOLD  = 2**LOG2_OF_DEPTH - 2,
  parameter int ALMOST_EMPTY_THRESHOLD = 1
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  input  logic                     flush,
  fifo_flex_if.slave               bus,
  output logic [LOG2_OF_DEPTH:0]   fill_level,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [LOG2_OF_DEPTH:0]   high_watermark
);
  localparam int AW    = LOG2_OF_DEPTH;
  localparam int DEPTH = 2**LOG2_OF_DEPTH;
  localparam logic [AW:0] LP_AF = (AW+1)'(ALMOST_FULL_THRESHOLD);
  localparam logic [AW:0] LP_AE = (AW+1)'(ALMOST_EMPTY_THRESHOLD);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_write_addr;
  logic [AW:0]      r_read_addr;
  logic [AW:0]      r_high_watermark;

  logic             w_empty;
  logic             w_full;
  logic             w_wr_en;
  logic             w_rd_en;
  logic [AW:0]      w_write_addr_next;
  logic [AW:0]      w_read_addr_next;
  logic [AW:0]      w_fill_next;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign w_empty = (r_write_addr == r_read_addr);
  assign w_full  = (r_write_addr[AW-1:0] == r_read_addr[AW-1:0]) &&
                   (r_write_addr[AW] != r_read_addr[AW]);

  assign w_wr_en = bus.input_valid && !w_full;
  assign w_rd_en = bus.output_ready && !w_empty;

  assign w_write_addr_next = r_write_addr + {{AW{1'b0}}, w_wr_en};
  assign w_read_addr_next  = r_read_addr + {{AW{1'b0}}, w_rd_en};
  assign w_fill_next       = w_write_addr_next - w_read_addr_next;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_write_addr     <= '0;
      r_read_addr      <= '0;
      r_high_watermark <= '0;
    end else if (flush) begin
      r_write_addr     <= '0;
      r_read_addr      <= '0;
      r_high_watermark <= '0;
    end else begin
      r_write_addr <= w_write_addr_next;
      r_read_addr  <= w_read_addr_next;
      if (w_fill_next > r_high_watermark) begin
        r_high_watermark <= w_fill_next;
      end
    end
  end

  // Storage is deliberately unreset; qout masking hides stale contents.
  always_ff @(posedge clk) begin
    if (w_wr_en && !flush) begin
      r_mem[r_write_addr[AW-1:0]] <= bus.din;
    end
  end

  assign bus.input_ready  = !w_full;
  assign bus.output_valid = !w_empty;
  assign bus.qout         = w_empty ? '0 : r_mem[r_read_addr[AW-1:0]];

  assign fill_level     = r_write_addr - r_read_addr;
  assign almost_full    = (fill_level >= LP_AF);
  assign almost_empty   = (fill_level <= LP_AE);
  assign high_watermark = r_high_watermark;
endmodule

// File: tb/tb_fifo_flex.sv
// Self-checking bench for fifo_flex: vector table, directed corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_fifo_flex;
  localparam int W     = 8;
  localparam int L     = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 1;

  logic         clk       = 1'b0;
  logic         arst_n_in = 1'b0;
  logic         flush     = 1'b0;
  logic [L:0]   fill_level;
  logic [L:0]   high_watermark;
  logic         almost_full;
  logic         almost_empty;

  fifo_flex_if #(.WIDTH(W)) u_if ();

  fifo_flex #(
    .WIDTH                  (W),
    .LOG2_OF_DEPTH          (L),
    .ALMOST_FULL_THRESHOLD  (AF),
    .ALMOST_EMPTY_THRESHOLD (AE)
  ) u_dut (
    .clk            (clk),
    .arst_n_in      (arst_n_in),
    .flush          (flush),
    .bus            (u_if),
    .fill_level     (fill_level),
    .almost_full    (almost_full),
    .almost_empty   (almost_empty),
    .high_watermark (high_watermark)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: contents as a plain queue, watermark as a running maximum.
  logic [7:0] mq[$];
  int         mhw = 0;

  typedef struct {
    logic       f;
    logic       iv;
    logic [7:0] d;
    logic       rd;
    logic [4:0] e_fill;
    logic       e_ov;
    logic [7:0] e_q;
    logic [4:0] e_hw;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int         sz;
    logic [7:0] head;
    sz   = mq.size();
    head = (sz > 0) ? mq[0] : 8'h00;
    chk({tag, " fill_level"},     32'(fill_level),       32'(sz));
    chk({tag, " input_ready"},    32'(u_if.input_ready), 32'(sz < DEPTH));
    chk({tag, " output_valid"},   32'(u_if.output_valid), 32'(sz > 0));
    chk({tag, " qout"},           32'(u_if.qout),        32'(head));
    chk({tag, " almost_full"},    32'(almost_full),      32'(sz >= AF));
    chk({tag, " almost_empty"},   32'(almost_empty),     32'(sz <= AE));
    chk({tag, " high_watermark"}, 32'(high_watermark),   32'(mhw));
  endtask

  task automatic model_edge(input logic f, input logic iv, input logic [7:0] d, input logic rd);
    if (f) begin
      mq.delete();
      mhw = 0;
    end else begin
      bit acc_w;
      bit acc_r;
      acc_w = iv && (mq.size() < DEPTH);
      acc_r = rd && (mq.size() > 0);
      if (acc_r) void'(mq.pop_front());
      if (acc_w) mq.push_back(d);
      if (mq.size() > mhw) mhw = mq.size();
    end
  endtask

  task automatic cycle(input logic f, input logic iv, input logic [7:0] d, input logic rd,
                       input string tag);
    flush             = f;
    u_if.input_valid  = iv;
    u_if.din          = d;
    u_if.output_ready = rd;
    @(posedge clk);
    model_edge(f, iv, d, rd);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    flush             = 1'b0;
    u_if.input_valid  = 1'b0;
    u_if.din          = 8'h00;
    u_if.output_ready = 1'b0;
    arst_n_in         = 1'b0;
    mq.delete();
    mhw = 0;
    repeat (2) @(posedge clk);
    #1;
    arst_n_in = 1'b1;
    check_model("reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Vector table from reset: FWFT write, simultaneous r/w, flush discards handshakes.
    tbl[0] = '{f:1'b0, iv:1'b1, d:8'hA5, rd:1'b0, e_fill:5'd1, e_ov:1'b1, e_q:8'hA5, e_hw:5'd1};
    tbl[1] = '{f:1'b0, iv:1'b1, d:8'h11, rd:1'b0, e_fill:5'd2, e_ov:1'b1, e_q:8'hA5, e_hw:5'd2};
    tbl[2] = '{f:1'b0, iv:1'b1, d:8'h22, rd:1'b1, e_fill:5'd2, e_ov:1'b1, e_q:8'h11, e_hw:5'd2};
    tbl[3] = '{f:1'b0, iv:1'b0, d:8'h00, rd:1'b1, e_fill:5'd1, e_ov:1'b1, e_q:8'h22, e_hw:5'd2};
    tbl[4] = '{f:1'b1, iv:1'b1, d:8'h33, rd:1'b1, e_fill:5'd0, e_ov:1'b0, e_q:8'h00, e_hw:5'd0};
    tbl[5] = '{f:1'b0, iv:1'b1, d:8'h3C, rd:1'b0, e_fill:5'd1, e_ov:1'b1, e_q:8'h3C, e_hw:5'd1};
    tbl[6] = '{f:1'b0, iv:1'b0, d:8'h00, rd:1'b1, e_fill:5'd0, e_ov:1'b0, e_q:8'h00, e_hw:5'd1};
    tbl[7] = '{f:1'b0, iv:1'b0, d:8'h00, rd:1'b1, e_fill:5'd0, e_ov:1'b0, e_q:8'h00, e_hw:5'd1};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].f, tbl[i].iv, tbl[i].d, tbl[i].rd, "vec");
      chk("vec fill_level",     32'(fill_level),        32'(tbl[i].e_fill));
      chk("vec output_valid",   32'(u_if.output_valid), 32'(tbl[i].e_ov));
      chk("vec qout",           32'(u_if.qout),         32'(tbl[i].e_q));
      chk("vec high_watermark", 32'(high_watermark),    32'(tbl[i].e_hw));
      $display("vec %0d: flush=%0b wr=%0b din=%02h rd=%0b -> fill=%0d qout=%02h hwm=%0d",
               i, tbl[i].f, tbl[i].iv, tbl[i].d, tbl[i].rd, fill_level, u_if.qout, high_watermark);
    end

    // Fill to full, then try a 17th write.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 8'(i), 1'b0, "fill");
      if (i == 12) chk("almost_full after 13th write", 32'(almost_full), 32'd0);
      if (i == 13) chk("almost_full after 14th write", 32'(almost_full), 32'd1);
    end
    chk("full input_ready", 32'(u_if.input_ready), 32'd0);
    chk("full fill_level",  32'(fill_level),       32'd16);
    cycle(1'b0, 1'b1, 8'hEE, 1'b0, "write17");
    chk("write17 fill_level",     32'(fill_level),     32'd16);
    chk("write17 high_watermark", 32'(high_watermark), 32'd16);
    $display("fill: 16 words written, fill=%0d hwm=%0d", fill_level, high_watermark);

    // Drain from full.
    for (int i = 0; i < 16; i++) begin
      chk("drain qout", 32'(u_if.qout), 32'(i));
      cycle(1'b0, 1'b0, 8'h00, 1'b1, "drain");
    end
    chk("drained output_valid",   32'(u_if.output_valid), 32'd0);
    chk("drained qout",           32'(u_if.qout),         32'd0);
    chk("drained almost_empty",   32'(almost_empty),      32'd1);
    chk("drained high_watermark", 32'(high_watermark),    32'd16);
    $display("drain: 16 words read, output_valid=%0b hwm=%0d", u_if.output_valid, high_watermark);

    // Steady streaming at fill level 5 across pointer wraps.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0, "prefill");
    for (int k = 0; k < 40; k++) begin
      chk("stream qout", 32'(u_if.qout), 32'(k));
      cycle(1'b0, 1'b1, 8'(5 + k), 1'b1, "stream");
      chk("stream fill_level", 32'(fill_level), 32'd5);
    end
    $display("stream: 40 simultaneous r/w at fill=%0d", fill_level);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, "stream drain");

    // Flush with concurrent handshakes.
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 8'(8'h50 + i), 1'b0, "flush prefill");
    chk("preflush fill_level", 32'(fill_level), 32'd9);
    cycle(1'b1, 1'b1, 8'h77, 1'b1, "flush");
    chk("flush fill_level",     32'(fill_level),        32'd0);
    chk("flush output_valid",   32'(u_if.output_valid), 32'd0);
    chk("flush high_watermark", 32'(high_watermark),    32'd0);
    cycle(1'b0, 1'b1, 8'h88, 1'b0, "postflush");
    chk("postflush qout",       32'(u_if.qout),  32'h88);
    chk("postflush fill_level", 32'(fill_level), 32'd1);
    $display("flush: fill=%0d qout=%02h after flush and one write", fill_level, u_if.qout);

    // Asynchronous reset mid-cycle with 7 words queued.
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'(8'h60 + i), 1'b0, "arst prefill");
    chk("prearst fill_level", 32'(fill_level), 32'd7);
    #3;
    arst_n_in = 1'b0;
    #1;
    chk("arst input_ready",    32'(u_if.input_ready),  32'd1);
    chk("arst output_valid",   32'(u_if.output_valid), 32'd0);
    chk("arst qout",           32'(u_if.qout),         32'd0);
    chk("arst fill_level",     32'(fill_level),        32'd0);
    chk("arst almost_full",    32'(almost_full),       32'd0);
    chk("arst almost_empty",   32'(almost_empty),      32'd1);
    chk("arst high_watermark", 32'(high_watermark),    32'd0);
    mq.delete();
    mhw = 0;
    u_if.input_valid  = 1'b0;
    u_if.output_ready = 1'b0;
    #1;
    arst_n_in = 1'b1;
    cycle(1'b0, 1'b1, 8'h3C, 1'b0, "post-arst");
    chk("post-arst qout", 32'(u_if.qout), 32'h3C);
    $display("arst: queue cleared, first write qout=%02h", u_if.qout);

    // Randomized traffic with biased phases to hit full and empty.
    for (int blk = 0; blk < 15; blk++) begin
      int wb;
      int rb;
      wb = $urandom_range(1, 3);
      rb = $urandom_range(1, 3);
      for (int c = 0; c < 200; c++) begin
        logic f;
        logic iv;
        logic rd;
        logic [7:0] d;
        f  = ($urandom_range(0, 99) == 0);
        iv = ($urandom_range(0, 3) < wb);
        rd = ($urandom_range(0, 3) < rb);
        d  = 8'($urandom);
        cycle(f, iv, d, rd, "rand");
      end
      $display("rand block %0d: wbias=%0d rbias=%0d fill=%0d hwm=%0d", blk, wb, rb, fill_level, high_watermark);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_flex.md
Name: fifo_flex

Overview:
- Parametrised successor to the accelerator's single-clock FIFO, used for stream buffering between compression and datapath stages.
- Flop-array storage with first-word-fall-through read: qout is valid in the same cycle as output_valid, with no read latency.
- Adds a fill-level output, programmable almost-full/almost-empty flags, a synchronous flush and a high-watermark register for buffer sizing.
- Valid/ready handshake on both ports; no combinational path from output_ready to input_ready or from input_valid to output_valid.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- LOG2_OF_DEPTH, 4, log2 of entry count; DEPTH = 2**LOG2_OF_DEPTH (>=1).
- ALMOST_FULL_THRESHOLD, 2**LOG2_OF_DEPTH-2, almost_full asserted when fill_level >= value; legal range 1..DEPTH.
- ALMOST_EMPTY_THRESHOLD, 1, almost_empty asserted when fill_level <= value; legal range 0..DEPTH-1.

Ports:
- clk  input  1  clock, all state on rising edge
- arst_n_in  input  1  asynchronous reset, active low
- flush  input  1  synchronous clear of contents and watermark
- din  input  WIDTH  write data
- input_valid  input  1  write request
- input_ready  output  1  FIFO not full
- qout  output  WIDTH  head-of-queue data (FWFT)
- output_valid  output  1  FIFO not empty
- output_ready  input  1  read acknowledge
- fill_level  output  LOG2_OF_DEPTH+1  current entry count, 0..DEPTH
- almost_full  output  1  fill_level >= ALMOST_FULL_THRESHOLD
- almost_empty  output  1  fill_level <= ALMOST_EMPTY_THRESHOLD
- high_watermark  output  LOG2_OF_DEPTH+1  maximum fill_level since reset or last flush

Behaviour:
- Pointers: write_addr and read_addr are LOG2_OF_DEPTH+1 bits wide. The low LOG2_OF_DEPTH bits index storage; the MSB is the wrap bit. Both increment modulo 2**(LOG2_OF_DEPTH+1).
- Status decode:
  - Empty: write_addr == read_addr.
  - Full: low bits equal and MSBs differ.
  - fill_level = write_addr - read_addr, modulo width. All status outputs decode from registers only.
- Write: when input_valid && input_ready, din is stored at mem[write_addr low bits] at the clock edge and write_addr increments. input_ready = !full and does not depend on output_ready. A write while full is not accepted, even if a read occurs in the same cycle.
- Read: qout = mem[read_addr low bits] when output_valid, else all zeros. When output_valid && output_ready, read_addr increments at the edge. output_valid = !empty; a word written in cycle N is visible on qout in cycle N+1.
- Simultaneous read and write when neither full nor empty: both occur and fill_level is unchanged.
- Ordering: data is strictly FIFO, with no loss or duplication across pointer wrap.
- Flush:
  - When flush=1 at an edge, both pointers become 0 and high_watermark becomes 0.
  - Any write or read handshake in the same cycle is discarded.
  - The next cycle shows empty.
  - Flush has priority over all other updates.
- high_watermark: registered. At each edge without flush, it updates to max(high_watermark, next fill_level), so it tracks the post-edge fill and never decreases except by flush or reset.
- Reset (arst_n_in=0, asynchronous): pointers = 0 and high_watermark = 0. Outputs during and after reset:
  - input_ready = 1, output_valid = 0, qout = 0, fill_level = 0
  - almost_full = 0, almost_empty = 1
- Storage is not reset; its contents are unobservable because qout is masked when empty.
- Reset mid-stream: all queued data is lost and the state is as after reset. The first handshake is accepted on the first edge after deassertion.
- Handshake inputs are ignored while the handshake condition is false; din and output_ready are don't-care when not qualified.
- DEPTH=2 (LOG2_OF_DEPTH=1) must work; the thresholds are evaluated on the full LOG2_OF_DEPTH+1-bit fill_level.

Test Plan (WIDTH=8, LOG2_OF_DEPTH=4, AF=14, AE=1):
- Reset, then write 16 words 0x00..0x0F with output_ready=0 → input_ready drops after the 16th write; fill_level=16; almost_full rises after the 14th write; high_watermark=16; a 17th input_valid is not accepted.
- From full, drain with output_ready=1 → qout sequence 0x00..0x0F, one per cycle; output_valid falls after the last read; qout=0; almost_empty=1; high_watermark stays 16.
- Continuous simultaneous read/write of 40 incrementing words at fill_level=5 → fill_level constant at 5; output order exact across two pointer wraps.
- Write 0xA5 into an empty FIFO → next cycle output_valid=1 and qout=0xA5 (FWFT, zero read latency).
- Fill to 9, then assert flush together with input_valid and output_ready → next cycle fill_level=0, output_valid=0, high_watermark=0; the flushed-cycle write is absent.
- Fill to 7, then assert arst_n_in=0 asynchronously mid-cycle → outputs go immediately to reset values; after deassertion, a write of 0x3C is read back first.
